// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_pkg;

   localparam int unsigned DATA_W_DEF  = 16;
   localparam int unsigned ADDR_W_DEF  = 11;
   localparam int unsigned REG_W_DEF   = 3;
   localparam int unsigned MEM_LAT_DEF = 2;
   localparam int unsigned CNT_W       = 3;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // Stack pointer reset value: the top word of a 2^aw-word memory.
   function automatic logic [31:0] sp_reset_val(input int unsigned aw);
      return (32'd1 << aw) - 32'd1;
   endfunction

   localparam logic [ADDR_W_DEF-1:0] SP_RESET = ADDR_W_DEF'(sp_reset_val(ADDR_W_DEF));

endpackage

// File: rtl/data_memory.sv
// Single-port word-addressed data RAM: write on the clock edge, read word
// presented combinationally so the owner can capture it on its completing edge.
module data_memory #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 11
)(
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rd_data_c
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   assign rd_data_c = mem_q[addr_i];

endmodule

// File: rtl/memory_stage.sv
// MEM stage: loads, stores, push and pop against the data RAM with a
// multi-cycle access, stack pointer ownership and the MEM/WB output registers.
module memory_stage
   import mem_pkg::*;
#(
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned REG_W   = REG_W_DEF,
   parameter int unsigned MEM_LAT = MEM_LAT_DEF
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              inValid,
   input  logic [DATA_W-1:0] aluDataIn,
   input  logic [DATA_W-1:0] storeData,
   input  logic [REG_W-1:0]  rdstIn,
   input  logic              memRead,
   input  logic              memWrite,
   input  logic              push,
   input  logic              pop,
   input  logic              regWriteIn,
   input  logic              memToRegIn,
   output logic              stall,
   output logic              outValid,
   output logic [DATA_W-1:0] memData,
   output logic [DATA_W-1:0] aluDataOut,
   output logic [REG_W-1:0]  rdstOut,
   output logic              regWriteOut,
   output logic              memToRegOut,
   output logic [ADDR_W-1:0] sp
);

   localparam logic [ADDR_W-1:0] SP_INIT = ADDR_W'(sp_reset_val(ADDR_W));

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:0]  sp_q, sp_d;
   logic [ADDR_W-1:0]  mem_addr;
   logic [DATA_W-1:0]  rd_data;
   logic               stack_any, pp_conflict;
   logic               is_push, is_pop, is_store, is_load, mem_op;
   logic               complete, stall_c, mem_we;

   logic               out_valid_q;
   logic [DATA_W-1:0]  mem_data_q;
   logic [DATA_W-1:0]  alu_data_q;
   logic [REG_W-1:0]   rdst_q;
   logic               reg_write_q;
   logic               mem_to_reg_q;

   // Operation decode; push&pop together is a plain pass-through, read&write is a store.
   always_comb begin
      stack_any   = push | pop;
      pp_conflict = push & pop;
      is_push     = inValid & push & ~pop;
      is_pop      = inValid & pop & ~push;
      is_store    = inValid & memWrite & ~stack_any;
      is_load     = inValid & memRead & ~memWrite & ~stack_any;
      mem_op      = is_push | is_pop | is_store | is_load;
      mem_addr    = aluDataIn[ADDR_W-1:0];
      if (is_push) begin
         mem_addr = sp_q;
      end else if (is_pop) begin
         mem_addr = sp_q + ADDR_W'(1);
      end
   end

   // Access sequencing: the access completes on the edge where stall is low.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      stall_c  = 1'b0;
      complete = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_op) begin
               if (MEM_LAT <= 1) begin
                  complete = 1'b1;
               end else begin
                  stall_c = 1'b1;
                  state_d = BUSY;
                  cnt_d   = CNT_W'(MEM_LAT - 2);
               end
            end else begin
               complete = inValid;
            end
         end
         BUSY: begin
            if (cnt_q != '0) begin
               stall_c = 1'b1;
               cnt_d   = cnt_q - CNT_W'(1);
            end else begin
               complete = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      sp_d = sp_q;
      if (complete && is_push) begin
         sp_d = sp_q - ADDR_W'(1);
      end else if (complete && is_pop) begin
         sp_d = sp_q + ADDR_W'(1);
      end
   end

   // A reset on the completing edge must not let a store or push commit.
   assign mem_we = complete & (is_push | is_store) & ~rst;

   data_memory #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_dmem (
      .clk       (clk),
      .we_i      (mem_we),
      .addr_i    (mem_addr),
      .wdata_i   (storeData),
      .rd_data_c (rd_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         sp_q         <= SP_INIT;
         out_valid_q  <= 1'b0;
         mem_data_q   <= '0;
         alu_data_q   <= '0;
         rdst_q       <= '0;
         reg_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sp_q        <= sp_d;
         out_valid_q <= complete;
         if (complete) begin
            mem_data_q   <= (is_load | is_pop) ? rd_data : '0;
            alu_data_q   <= aluDataIn;
            rdst_q       <= rdstIn;
            reg_write_q  <= regWriteIn & ~pp_conflict;
            mem_to_reg_q <= memToRegIn;
         end else begin
            reg_write_q  <= 1'b0;
         end
      end
   end

   assign stall       = stall_c;
   assign outValid    = out_valid_q;
   assign memData     = mem_data_q;
   assign aluDataOut  = alu_data_q;
   assign rdstOut     = rdst_q;
   assign regWriteOut = reg_write_q;
   assign memToRegOut = mem_to_reg_q;
   assign sp          = sp_q;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: a reference model predicts each MEM/WB
// result into a queue, and a monitor pops and compares on every valid output.
module tb_memory_stage;

   localparam int unsigned DW  = 16;
   localparam int unsigned AW  = 11;
   localparam int unsigned RW  = 3;
   localparam int unsigned LAT = 2;

   logic          clk;
   logic          rst;
   logic          inValid;
   logic [DW-1:0] aluDataIn;
   logic [DW-1:0] storeData;
   logic [RW-1:0] rdstIn;
   logic          memRead, memWrite, push, pop, regWriteIn, memToRegIn;
   logic          stall, outValid, regWriteOut, memToRegOut;
   logic [DW-1:0] memData, aluDataOut;
   logic [RW-1:0] rdstOut;
   logic [AW-1:0] sp;

   typedef struct packed {
      logic [DW-1:0] mdata;
      logic [DW-1:0] alu;
      logic [RW-1:0] rdst;
      logic          rw;
      logic          m2r;
      logic [AW-1:0] sp;
   } exp_t;

   exp_t          sb_q[$];
   logic [DW-1:0] model_mem [int];
   logic [AW-1:0] m_sp;
   int            checks = 0;
   int            errors = 0;

   memory_stage #(
      .DATA_W (DW), .ADDR_W (AW), .REG_W (RW), .MEM_LAT (LAT)
   ) dut (
      .clk (clk), .rst (rst), .inValid (inValid), .aluDataIn (aluDataIn),
      .storeData (storeData), .rdstIn (rdstIn), .memRead (memRead),
      .memWrite (memWrite), .push (push), .pop (pop), .regWriteIn (regWriteIn),
      .memToRegIn (memToRegIn), .stall (stall), .outValid (outValid),
      .memData (memData), .aluDataOut (aluDataOut), .rdstOut (rdstOut),
      .regWriteOut (regWriteOut), .memToRegOut (memToRegOut), .sp (sp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Scoreboard monitor: every valid MEM/WB slot must match the oldest prediction.
   always begin : monitor
      exp_t e;
      @(posedge clk);
      #1;
      if (outValid === 1'b1) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: outValid=1 but no result expected (aluDataOut=%h)", aluDataOut);
         end else begin
            e = sb_q.pop_front();
            if (memData !== e.mdata) begin
               errors++; $display("FAIL memData: got %h expected %h", memData, e.mdata);
            end
            checks++;
            if (aluDataOut !== e.alu) begin
               errors++; $display("FAIL aluDataOut: got %h expected %h", aluDataOut, e.alu);
            end
            checks++;
            if (rdstOut !== e.rdst) begin
               errors++; $display("FAIL rdstOut: got %0d expected %0d", rdstOut, e.rdst);
            end
            checks++;
            if (regWriteOut !== e.rw) begin
               errors++; $display("FAIL regWriteOut: got %b expected %b", regWriteOut, e.rw);
            end
            checks++;
            if (memToRegOut !== e.m2r) begin
               errors++; $display("FAIL memToRegOut: got %b expected %b", memToRegOut, e.m2r);
            end
            checks++;
            if (sp !== e.sp) begin
               errors++; $display("FAIL sp: got %h expected %h", sp, e.sp);
            end
         end
      end
   end

   task automatic clear_inputs();
      inValid = 1'b0; memRead = 1'b0; memWrite = 1'b0; push = 1'b0; pop = 1'b0;
      regWriteIn = 1'b0; memToRegIn = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst  = 1'b0;
      m_sp = '1;
      sb_q.delete();
   endtask

   // Drive one instruction, predict its result, hold it until the DUT accepts it.
   task automatic drive_op(input logic rd, input logic wr, input logic ps, input logic pp,
                           input logic rw, input logic m2r, input logic [DW-1:0] alu,
                           input logic [DW-1:0] sd, input logic [RW-1:0] rd_idx,
                           output int stalls);
      exp_t     e;
      logic     conflict;
      logic     st;
      logic [AW-1:0] a;
      bit       done;
      inValid = 1'b1; memRead = rd; memWrite = wr; push = ps; pop = pp;
      regWriteIn = rw; memToRegIn = m2r; aluDataIn = alu; storeData = sd; rdstIn = rd_idx;
      conflict = ps & pp;
      a        = alu[AW-1:0];
      e.alu    = alu;
      e.rdst   = rd_idx;
      e.m2r    = m2r;
      e.rw     = rw & ~conflict;
      e.mdata  = '0;
      if (!conflict && ps) begin
         model_mem[int'(m_sp)] = sd;
         m_sp = m_sp - 1'b1;
      end else if (!conflict && pp) begin
         m_sp = m_sp + 1'b1;
         e.mdata = model_mem[int'(m_sp)];
      end else if (!conflict && wr) begin
         model_mem[int'(a)] = sd;
      end else if (!conflict && rd) begin
         e.mdata = model_mem[int'(a)];
      end
      e.sp = m_sp;
      sb_q.push_back(e);
      stalls = 0;
      done   = 1'b0;
      for (int g = 0; g < 20 && !done; g++) begin
         #1;
         st = stall;
         @(posedge clk);
         #1;
         if (st === 1'b0) done = 1'b1;
         else stalls++;
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL accept_timeout: stall still high after 20 cycles (alu=%h)", alu);
      end
   endtask

   task automatic go_idle();
      clear_inputs();
      @(posedge clk);
      #1;
      checks++;
      if (outValid !== 1'b0 || regWriteOut !== 1'b0 || stall !== 1'b0) begin
         errors++;
         $display("FAIL idle: outValid=%b regWriteOut=%b stall=%b expected 0 0 0",
                  outValid, regWriteOut, stall);
      end
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++;
      if (sp !== 11'h7FF) begin errors++; $display("FAIL reset_sp: got %h expected 7ff", sp); end
      checks++;
      if (outValid !== 1'b0 || regWriteOut !== 1'b0) begin
         errors++; $display("FAIL reset_valid: outValid=%b regWriteOut=%b expected 0 0", outValid, regWriteOut);
      end
      checks++;
      if (memData !== 16'h0 || aluDataOut !== 16'h0) begin
         errors++; $display("FAIL reset_data: memData=%h aluDataOut=%h expected 0 0", memData, aluDataOut);
      end
      checks++;
      if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_store_load();
      int s;
      drive_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0010, 16'hBEEF, 3'd0, s);
      checks++;
      if (s != LAT - 1) begin errors++; $display("FAIL store_stalls: got %0d expected %0d", s, LAT - 1); end
      drive_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0010, 16'h0000, 3'd5, s);
      checks++;
      if (s != LAT - 1) begin errors++; $display("FAIL load_stalls: got %0d expected %0d", s, LAT - 1); end
      // Read and write together behave as a store only.
      drive_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'hF811, 16'h4242, 3'd1, s);
      drive_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0011, 16'h0000, 3'd6, s);
      go_idle();
   endtask

   task automatic test_push_pop();
      int s;
      drive_op(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234, 3'd0, s);
      drive_op(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h5678, 3'd0, s);
      drive_op(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000, 3'd2, s);
      checks++;
      if (s != LAT - 1) begin errors++; $display("FAIL pop_stalls: got %0d expected %0d", s, LAT - 1); end
      drive_op(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000, 3'd3, s);
      go_idle();
   endtask

   task automatic test_pop_wrap();
      int s;
      drive_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hCAFE, 3'd0, s);
      go_idle();
      do_reset();
      drive_op(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000, 3'd1, s);
      drive_op(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0ABC, 3'd0, s);
      go_idle();
      checks++;
      if (sp !== 11'h7FF) begin errors++; $display("FAIL wrap_sp: got %h expected 7ff", sp); end
   endtask

   task automatic test_alu_and_conflict();
      int s;
      drive_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h00AA, 16'h0000, 3'd4, s);
      checks++;
      if (s != 0) begin errors++; $display("FAIL alu_stalls: got %0d expected 0", s); end
      drive_op(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0055, 16'h9999, 3'd7, s);
      checks++;
      if (s != 0) begin errors++; $display("FAIL conflict_stalls: got %0d expected 0", s); end
      go_idle();
   endtask

   task automatic test_reset_mid_busy();
      int s;
      drive_op(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h7777, 3'd0, s);
      drive_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h1111, 3'd0, s);
      go_idle();
      inValid = 1'b1; memWrite = 1'b1; aluDataIn = 16'h0020; storeData = 16'h2222;
      #1;
      checks++;
      if (stall !== 1'b1) begin errors++; $display("FAIL busy_stall: got %b expected 1", stall); end
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_inputs();
      m_sp = '1;
      checks++;
      if (sp !== 11'h7FF || outValid !== 1'b0) begin
         errors++; $display("FAIL abort_state: sp=%h outValid=%b expected 7ff 0", sp, outValid);
      end
      checks++;
      if (sb_q.size() != 0) begin
         errors++; $display("FAIL abort_queue: %0d results pending expected 0", sb_q.size());
      end
      drive_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0020, 16'h0000, 3'd2, s);
      go_idle();
   endtask

   initial begin
      clear_inputs();
      rst = 1'b1; aluDataIn = '0; storeData = '0; rdstIn = '0; m_sp = '1;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_store_load();
      test_push_pop();
      test_pop_wrap();
      test_alu_and_conflict();
      test_reset_mid_busy();
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (sb_q.size() != 0) begin
         errors++; $display("FAIL drain: %0d results never produced, expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
